// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-to-1 channel multiplexer with a valid/ready
// output stage. A channel is chosen either by a loadable select register
// (manual mode) or by a round-robin scan pointer (auto mode). A capture
// takes one cycle, and the captured channel is acknowledged combinationally.
module mux_scan_reg #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ack,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Output register and control state
  logic [WIDTH-1:0] r_outData;
  logic [SEL_W-1:0] r_outCh;
  logic             r_outValid;
  logic [SEL_W-1:0] r_selQ;
  logic [SEL_W-1:0] r_ptrQ;

  // Combinational selection results
  logic [SEL_W-1:0] w_probe;
  logic [SEL_W-1:0] w_autoIdx;
  logic             w_autoFound;
  logic [SEL_W-1:0] w_cand;
  logic             w_candValid;
  logic [WIDTH-1:0] w_candData;
  logic             w_accept;
  logic             w_capture;

  // Circular priority search from the scan pointer. The offsets are walked
  // from the farthest back to the nearest, so the nearest valid channel is
  // the one left standing. CHANNELS is a power of two, so the SEL_W-bit add
  // wraps from CHANNELS-1 to 0 by itself.
  always_comb begin
    w_probe     = '0;
    w_autoIdx   = r_ptrQ;
    w_autoFound = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_probe = r_ptrQ + SEL_W'(i);
      if (in_valid[w_probe]) begin
        w_autoFound = 1'b1;
        w_autoIdx   = w_probe;
      end
    end
  end

  // Choose the candidate channel for this cycle and decide whether it is taken.
  // While rst_n is low nothing is captured, so no acknowledge can escape.
  always_comb begin
    w_cand      = mode ? w_autoIdx : r_selQ;
    w_candValid = mode ? w_autoFound : in_valid[r_selQ];
    w_candData  = in_data[int'(w_cand)*WIDTH +: WIDTH];
    w_accept    = !r_outValid || out_ready;
    w_capture   = rst_n && w_accept && w_candValid;
  end

  // One-hot acknowledge of the channel being captured this cycle
  always_comb begin
    in_ack = '0;
    if (w_capture) begin
      in_ack[w_cand] = 1'b1;
    end
  end

  // Output stage: load on capture, hold under back-pressure, empty otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outCh    <= '0;
      r_outValid <= 1'b0;
    end else if (w_accept) begin
      r_outValid <= w_capture;
      if (w_capture) begin
        r_outData <= w_candData;
        r_outCh   <= w_cand;
      end
    end
  end

  // Scan pointer moves just past the channel served, on auto-mode captures only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptrQ <= '0;
    end else if (w_capture && mode) begin
      r_ptrQ <= w_cand + SEL_W'(1);
    end
  end

  // Manual select register; a same-cycle capture still sees the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_selQ <= '0;
    end else if (sel_load) begin
      r_selQ <= sel;
    end
  end

  assign out_data  = r_outData;
  assign out_ch    = r_outCh;
  assign out_valid = r_outValid;

endmodule

// File: doc/mux_scan_reg.md
# mux_scan_reg

Parametrised, registered N-to-1 channel multiplexer with a valid/ready output stage. It supports two modes: manual select and round-robin auto-scan. It supersedes the purely combinational 4:1/16:1 mux trees for datapaths that must pick one of several producer channels per cycle and hand the result to a back-pressuring consumer. Each transfer has one cycle of latency; the capture stage holds its data under back-pressure and acknowledges the channel it took.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 16, number of input channels; power of two, 2..16
- SEL_W, log2(CHANNELS), channel index width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous and active-low
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data-valid
- in_ack  output  CHANNELS  combinational one-hot; bit i high in the cycle channel i is captured
- mode  input  1  0 = manual select, 1 = round-robin auto-scan
- sel  input  SEL_W  manual channel index
- sel_load  input  1  load sel into the select register at the next edge
- out_data  output  WIDTH  registered selected data
- out_ch  output  SEL_W  registered index of the channel held in out_data
- out_valid  output  1  out_data/out_ch hold a transfer
- out_ready  input  1  consumer accepts the transfer when out_valid & out_ready

## Operation
- State: output register (out_data, out_ch, out_valid), select register sel_q, scan pointer ptr_q.
- accept = !out_valid | out_ready. The capture stage may load only when accept = 1.
- Manual mode (mode=0):
  - Candidate is c = sel_q.
  - Capture occurs when accept & in_valid[c]. On capture: out_data <= channel c data, out_ch <= c, out_valid <= 1, in_ack[c] = 1.
- Auto mode (mode=1):
  - Candidate c is the first index with in_valid high, searched circularly from ptr_q upward: ptr_q, ptr_q+1, …, CHANNELS-1, 0, ….
  - On capture, ptr_q <= c+1 modulo CHANNELS. The index wraps from CHANNELS-1 to 0.
- No capture when accept=1 and the candidate is not valid (or no channel is valid in auto mode). In that case out_valid <= 0, in_ack = 0, and ptr_q is unchanged.
- Back-pressure: when out_valid & !out_ready, out_data, out_ch, out_valid, ptr_q are held and in_ack = 0.
- sel_load:
  - sel_q <= sel at the edge.
  - A capture in the same cycle uses the old sel_q.
  - sel_load is honoured in either mode.
- ptr_q advances only on auto-mode captures. It is unaffected by manual-mode operation and by mode changes.
- mode is sampled every cycle. A switch takes effect on the first edge where it is seen. An already captured output is not disturbed.
- in_ack is a pure function of current state and inputs. It never asserts for a channel whose in_valid is low.

## Timing
- Reset (rst_n low, asynchronous): out_data=0, out_ch=0, out_valid=0, sel_q=0, ptr_q=0. Reset mid-transfer discards held data. in_ack follows the reset state, i.e. no capture while rst_n is low.
- Latency: channel data captured at edge k appears on out_data after edge k, with out_valid=1.
- Throughput: one transfer per cycle while out_ready is held high and the candidate is valid. A simultaneous pop and capture is allowed in the same cycle.
- A transfer completes at the edge where out_valid & out_ready. If no new capture happens at that edge, out_valid falls after it.
- Producers must hold in_data/in_valid until in_ack. They may drop in_valid without ack, in which case no capture occurs.
- Auto mode is fair: with all channels valid and out_ready=1, the channels are served 0,1,…,CHANNELS-1,0,… in consecutive cycles.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-transfer, with out_valid=1 and out_ready=0.
  - Response: out_valid=0, out_data=0, out_ch=0, sel_q=ptr_q=0 immediately, without waiting for a clock edge.
  - After release, with in_valid=0, out_valid stays 0.
- Manual select (WIDTH=8, CHANNELS=16):
  - Stimulus: sel=5 with sel_load=1 for one cycle; channel 5 = 0xA5 and valid; out_ready=1.
  - Response: one cycle after the load edge, in_ack=0x0020; the next cycle shows out_data=0xA5, out_ch=5, out_valid=1.
- Back-pressure:
  - Stimulus: a capture of 0x3C, then out_ready=0 for 3 cycles while channel data changes.
  - Response: out_data stays 0x3C, out_valid stays 1, in_ack=0 for those 3 cycles.
  - Then: out_ready=1 completes the transfer and the next capture happens on the same edge.
- Auto-scan fairness with wrap:
  - Stimulus: mode=1, ptr_q=0, in_valid=0x8009, out_ready=1 steady.
  - Response: captures in order ch0, ch3, ch15, ch0, with ptr_q wrapping from 15 to 0.
- Auto skip/none valid:
  - Stimulus: in_valid=0 while out_ready=1.
  - Response: out_valid drops after one cycle; ptr_q is held.
  - Then: in_valid=0x0100 gives out_ch=8 next cycle, and ptr_q becomes 9.
- Simultaneous events:
  - Stimulus: sel_load=1 with sel=2, in the same cycle as a manual capture from sel_q=7.
  - Response: ch7 is captured (in_ack=0x0080), and the next capture comes from ch2.
  - Also: toggle mode under back-pressure; the held output is unchanged.
